alu_operand_issue: RTL and testbench
====================================

Name: alu_operand_issue

Overview:
Upstream issue stage for the 8-bit combinational ALU. Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO. Presents one registered {a, b, op} beat at a time to the ALU inputs, with downstream backpressure. A built-in sweep mode generates the standard exhaustive stimulus pattern in hardware: a steps every beat, b every 2 beats, op every 16 beats.

Parameters:
WIDTH, 8, operand width of a, b and alu_a, alu_b.
OPW, 3, opcode width; OPW+3 <= WIDTH is required.
DEPTH, 4, FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  command present.
in_ready  output  1  FIFO can accept.
in_a  input  WIDTH  operand a.
in_b  input  WIDTH  operand b.
in_op  input  OPW  opcode.
sweep_en  input  1  1 = sweep mode, 0 = FIFO mode.
alu_a  output  WIDTH  registered operand a to ALU.
alu_b  output  WIDTH  registered operand b to ALU.
alu_op  output  OPW  registered opcode to ALU.
alu_valid  output  1  alu_* hold a live beat.
alu_ready  input  1  consumer takes the beat this cycle.
count  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset is sampled on the clk edge.
  - After reset: alu_a = 0, alu_b = 0, alu_op = 0, alu_valid = 0, count = 0, FIFO pointers = 0, sweep counter k = 0.
  - in_ready = 0 while rst = 1. Reset mid-operation discards the FIFO contents and any held beat.
- in_ready = (count < DEPTH) and not rst.
  - in_ready does not depend on same-cycle pop and is independent of mode. The FIFO accepts commands during sweep and retains them.
- Push = in_valid & in_ready. Pop = FIFO head loaded into the issue register. Simultaneous push and pop leave count unchanged.
- Free slot: free = !alu_valid | alu_ready. The issue register updates only when free = 1. When free = 0, all alu_* outputs hold stable.
- Mode (sweep_en) is sampled only on edges where free = 1. A stalled beat is never dropped or altered by a mode change.
- FIFO mode (sweep_en = 0) at a free edge:
  - FIFO non-empty: load the head into alu_*, set alu_valid = 1, pop.
  - FIFO empty: alu_valid = 0; alu_a, alu_b, alu_op hold their previous values.
  - No bypass. A command pushed on edge N is at the earliest on alu_* after edge N+1.
- Sweep mode (sweep_en = 1) at a free edge:
  - k is a WIDTH+1-bit beat counter.
  - Entry from FIFO mode (previous free edge was not sweep): k <- 0 and alu_{a, b, op} <- 0, 0, 0.
  - Otherwise k <- k+1 and the issue register loads from k+1 as:
    - alu_a = (k+1)[WIDTH-1:0]
    - alu_b = (k+1)[WIDTH:1]
    - alu_op = (k+1)[OPW+3:4]
  - alu_valid = 1 throughout sweep. There is no FIFO pop.
  - k wraps naturally at 2^(WIDTH+1). a wraps every 256 beats, b every 512 beats, op every 128 beats (default widths).
- Leaving sweep (sweep_en = 0 at a free edge) follows the FIFO-mode rule on that same edge.
- count wraps nothing: push when full is impossible, and pop when empty is impossible by construction.

Test Plan:
- Reset then idle, rst = 1 for 2 cycles then 0 → all alu_* = 0, alu_valid = 0, count = 0, in_ready = 1 one cycle after rst falls.
- Latency: alu_ready = 1, single push {a=0x12, b=0x34, op=5} on edge N → count = 1 after N, alu_* = {0x12, 0x34, 5} with alu_valid = 1 after N+1, count = 0 after N+1.
- Backpressure, DEPTH = 4: alu_ready = 0, push 6 commands 1..6 → command 1 in the issue register, 2..5 in the FIFO, count = 4, in_ready = 0, command 6 waits. Release alu_ready → beats delivered 1..6 in order, no loss or duplication.
- Sweep, alu_ready = 1, sweep_en = 1 from idle → beats 0..17 are (a, b, op) = (00,00,0), (01,00,0), (02,01,0), (03,01,0) … (0F,07,0), (10,08,1), (11,08,1). Beat 256 = (00,80,0).
- Mode switch during stall: sweep at beat (05,02,0), alu_ready = 0, drop sweep_en with FIFO holding {0xAA, 0x55, 3} → alu_* holds (05,02,0) until alu_ready = 1, then next beat = {0xAA, 0x55, 3}. Re-entering sweep restarts at (00,00,0).
- Reset mid-operation: FIFO count = 3, alu_valid = 1, rst pulsed 1 cycle → count = 0, alu_valid = 0, alu_* = 0. A subsequent push behaves as in the latency test.

Source files
------------

// File: rtl/alu_operand_issue.sv
// Operand issue stage for the 8-bit ALU: command FIFO plus registered issue slot,
// with a hardware sweep generator for exhaustive operand/opcode stimulus.
module alu_operand_issue #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OPW-1:0]   in_op,
    input  logic             sweep_en,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [CW-1:0]    count
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [OPW-1:0]   op;
    } cmd_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [WIDTH:0] k;
    logic [WIDTH:0] kn;
    logic          in_sweep;
    logic          free;
    logic          empty;
    logic          push;
    logic          pop;

    always_comb begin
        in_ready = (count != CW'(DEPTH)) && !rst;
        free     = !alu_valid || alu_ready;
        empty    = (count == '0);
        push     = in_valid && in_ready;
        pop      = free && !sweep_en && !empty;
        head     = mem[rd_ptr];
        kn       = k + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            k         <= '0;
            in_sweep  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (free) begin
                in_sweep <= sweep_en;
                if (sweep_en) begin
                    alu_valid <= 1'b1;
                    // First sweep beat after FIFO mode restarts the pattern at zero
                    if (!in_sweep) begin
                        k      <= '0;
                        alu_a  <= '0;
                        alu_b  <= '0;
                        alu_op <= '0;
                    end else begin
                        k      <= kn;
                        alu_a  <= kn[WIDTH-1:0];
                        alu_b  <= kn[WIDTH:1];
                        alu_op <= kn[OPW+3:4];
                    end
                end else begin
                    alu_valid <= !empty;
                    if (!empty) begin
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed bench for alu_operand_issue: reset, latency, backpressure,
// sweep pattern table, mode switch under stall and mid-operation reset.
module tb_alu_operand_issue;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       sweep_en;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    alu_operand_issue #(.WIDTH(8), .OPW(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .sweep_en(sweep_en),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         beat;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } sweep_vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    sweep_vec_t tbl[12];
    cmd_t       cmds[6];
    int         pi;
    int         got;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] op);
        chk({nm, ".a"}, {24'd0, alu_a}, {24'd0, a});
        chk({nm, ".b"}, {24'd0, alu_b}, {24'd0, b});
        chk({nm, ".op"}, {29'd0, alu_op}, {29'd0, op});
        chk({nm, ".valid"}, {31'd0, alu_valid}, 32'd1);
    endtask

    task automatic latency_test(input string nm);
        in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34; in_op = 3'd5;
        step();
        in_valid = 1'b0;
        chk({nm, ".count_n"}, {29'd0, count}, 32'd1);
        chk({nm, ".valid_n"}, {31'd0, alu_valid}, 32'd0);
        step();
        chk_beat({nm, ".beat_n1"}, 8'h12, 8'h34, 3'd5);
        chk({nm, ".count_n1"}, {29'd0, count}, 32'd0);
        step();
        chk({nm, ".idle_valid"}, {31'd0, alu_valid}, 32'd0);
        chk({nm, ".idle_hold_a"}, {24'd0, alu_a}, 32'h12);
    endtask

    // Offers commands in order and scores each beat the consumer takes
    task automatic push_and_watch(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (alu_valid && alu_ready) begin
                if (got < 6) begin
                    chk($sformatf("order.beat%0d.a", got), {24'd0, alu_a}, {24'd0, cmds[got].a});
                    chk($sformatf("order.beat%0d.b", got), {24'd0, alu_b}, {24'd0, cmds[got].b});
                    chk($sformatf("order.beat%0d.op", got), {29'd0, alu_op}, {29'd0, cmds[got].op});
                end else begin
                    chk("order.extra_beat", 32'(got), 32'd5);
                end
                got++;
            end
            in_valid = (pi < 6);
            if (pi < 6) begin
                in_a = cmds[pi].a; in_b = cmds[pi].b; in_op = cmds[pi].op;
            end
            if (in_valid && in_ready) begin
                step();
                pi++;
            end else begin
                step();
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{0,   8'h00, 8'h00, 3'd0};
        tbl[1]  = '{1,   8'h01, 8'h00, 3'd0};
        tbl[2]  = '{2,   8'h02, 8'h01, 3'd0};
        tbl[3]  = '{3,   8'h03, 8'h01, 3'd0};
        tbl[4]  = '{15,  8'h0F, 8'h07, 3'd0};
        tbl[5]  = '{16,  8'h10, 8'h08, 3'd1};
        tbl[6]  = '{17,  8'h11, 8'h08, 3'd1};
        tbl[7]  = '{128, 8'h80, 8'h40, 3'd0};
        tbl[8]  = '{255, 8'hFF, 8'h7F, 3'd7};
        tbl[9]  = '{256, 8'h00, 8'h80, 3'd0};
        tbl[10] = '{511, 8'hFF, 8'hFF, 3'd7};
        tbl[11] = '{512, 8'h00, 8'h00, 3'd0};
        for (int i = 0; i < 6; i++) begin
            cmds[i] = '{8'h11 + 8'(i), 8'h21 + 8'(i), 3'(i + 1)};
        end

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        sweep_en = 1'b0; alu_ready = 1'b1;

        // Reset then idle
        step();
        chk("rst.in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst.alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst.alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst.alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst.valid", {31'd0, alu_valid}, 32'd0);
        chk("rst.count", {29'd0, count}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);

        latency_test("lat");

        // Backpressure: fill issue slot plus FIFO, then drain in order
        alu_ready = 1'b0;
        pi = 0; got = 0;
        push_and_watch(8);
        chk("bp.count_full", {29'd0, count}, 32'd4);
        chk("bp.in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp.pushed", 32'(pi), 32'd5);
        chk_beat("bp.head", cmds[0].a, cmds[0].b, cmds[0].op);
        alu_ready = 1'b1;
        push_and_watch(20);
        chk("bp.delivered", 32'(got), 32'd6);
        chk("bp.drained", {29'd0, count}, 32'd0);
        chk("bp.idle", {31'd0, alu_valid}, 32'd0);

        // Mode switch during a stalled sweep beat
        sweep_en = 1'b1;
        in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_op = 3'd3;
        step();
        in_valid = 1'b0;
        chk_beat("ms.beat0", 8'h00, 8'h00, 3'd0);
        chk("ms.count_sweep", {29'd0, count}, 32'd1);
        for (int i = 0; i < 5; i++) step();
        chk_beat("ms.beat5", 8'h05, 8'h02, 3'd0);
        alu_ready = 1'b0; sweep_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk_beat("ms.hold", 8'h05, 8'h02, 3'd0);
        chk("ms.count_hold", {29'd0, count}, 32'd1);
        alu_ready = 1'b1;
        step();
        chk_beat("ms.fifo_beat", 8'hAA, 8'h55, 3'd3);
        chk("ms.count_pop", {29'd0, count}, 32'd0);
        sweep_en = 1'b1;
        step();
        chk_beat("ms.reentry", 8'h00, 8'h00, 3'd0);
        step();
        chk_beat("ms.reentry1", 8'h01, 8'h00, 3'd0);

        // Full sweep pattern against the table
        sweep_en = 1'b0;
        step();
        chk("sw.leave_valid", {31'd0, alu_valid}, 32'd0);
        sweep_en = 1'b1;
        begin
            int ti = 0;
            for (int beat = 0; beat <= 512; beat++) begin
                step();
                if (ti < 12 && tbl[ti].beat == beat) begin
                    chk_beat($sformatf("sw.beat%0d", beat), tbl[ti].a, tbl[ti].b, tbl[ti].op);
                    ti++;
                end
            end
            chk("sw.table_done", 32'(ti), 32'd12);
        end
        sweep_en = 1'b0;
        step();

        // Reset mid-operation
        alu_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = cmds[i].a; in_b = cmds[i].b; in_op = cmds[i].op;
            step();
        end
        in_valid = 1'b0;
        chk("mr.count_pre", {29'd0, count}, 32'd3);
        chk("mr.valid_pre", {31'd0, alu_valid}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr.count", {29'd0, count}, 32'd0);
        chk("mr.valid", {31'd0, alu_valid}, 32'd0);
        chk("mr.alu_a", {24'd0, alu_a}, 32'd0);
        chk("mr.alu_b", {24'd0, alu_b}, 32'd0);
        chk("mr.alu_op", {29'd0, alu_op}, 32'd0);
        alu_ready = 1'b1;
        latency_test("mr.lat");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
